// File: rtl/lfsr_gen_if.sv
// Valid/ready stream and control bundle between an LFSR generator and its consumer.
// The master side drives load/seed/clear/ready; the slave side (the generator) drives the stream.
interface lfsr_gen_if #(
  parameter int WIDTH   = 25,
  parameter int COUNT_W = 32
);
  logic               i_load;
  logic [WIDTH-1:0]   i_seed;
  logic               i_clear;
  logic               i_ready;
  logic               o_valid;
  logic [WIDTH-1:0]   o_data;
  logic [COUNT_W-1:0] o_count;
  logic               o_wrap;
  logic               o_seed_fix;

  modport master (
    output i_load, i_seed, i_clear, i_ready,
    input  o_valid, o_data, o_count, o_wrap, o_seed_fix
  );

  modport slave (
    input  i_load, i_seed, i_clear, i_ready,
    output o_valid, o_data, o_count, o_wrap, o_seed_fix
  );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised LFSR stream source: Fibonacci/Galois, XOR/XNOR, STEPS shifts per transfer,
// valid/ready output, lock-up seed substitution, transfer counter and period-wrap pulse.
module lfsr_gen #(
  parameter int               WIDTH        = 25,
  parameter logic [WIDTH-1:0] TAPS         = 25'h1200000,
  parameter int               MODE         = 0,
  parameter int               FEEDBACK     = 0,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1),
  parameter int               COUNT_W      = 32
) (
  input logic       i_clk,
  input logic       i_rst,
  lfsr_gen_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [WIDTH-1:0] LOCKUP = (FEEDBACK == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  // Galois XNOR is the complement dual of Galois XOR, so all-ones stays the lock-up state.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] nxt;
    logic             fb;
    nxt = s;
    fb  = 1'b0;
    if (MODE == 0) begin
      fb  = (^(s & TAPS)) ^ (FEEDBACK == 1);
      nxt = {s[WIDTH-2:0], fb};
    end else if (FEEDBACK == 0) begin
      nxt = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAPS : {WIDTH{1'b0}});
    end else begin
      nxt = {s[WIDTH-2:0], 1'b1} ^ (s[WIDTH-1] ? {WIDTH{1'b0}} : TAPS);
    end
    return nxt;
  endfunction

  state_e             fsm_q,   fsm_d;
  logic [WIDTH-1:0]   lfsr_q,  lfsr_d;
  logic [WIDTH-1:0]   seed_q,  seed_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               wrap_q,  wrap_d;
  logic               fix_q,   fix_d;

  logic [WIDTH-1:0]   adv;
  logic [WIDTH-1:0]   seed_in;
  logic               seed_locked;
  logic               xfer;

  always_comb begin
    adv = lfsr_q;
    for (int i = 0; i < STEPS; i++) begin
      adv = step1(adv);
    end
  end

  assign seed_locked = (bus.i_seed == LOCKUP);
  assign seed_in     = seed_locked ? DEFAULT_SEED : bus.i_seed;
  assign xfer        = (fsm_q == RUN) && bus.i_ready;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    fsm_d   = fsm_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    fix_d   = 1'b0;
    if (bus.i_load) begin
      fsm_d   = RUN;
      lfsr_d  = seed_in;
      seed_d  = seed_in;
      count_d = '0;
      fix_d   = seed_locked;
    end else if (bus.i_clear) begin
      fsm_d = IDLE;
    end else if (xfer) begin
      lfsr_d  = adv;
      count_d = count_q + COUNT_W'(1);
      wrap_d  = (adv == seed_q);
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (i_rst) begin
      fsm_q   <= IDLE;
      lfsr_q  <= DEFAULT_SEED;
      seed_q  <= DEFAULT_SEED;
      count_q <= '0;
      wrap_q  <= 1'b0;
      fix_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      fix_q   <= fix_d;
    end
  end

  assign bus.o_valid    = (fsm_q == RUN);
  assign bus.o_data     = lfsr_q;
  assign bus.o_count    = count_q;
  assign bus.o_wrap     = wrap_q;
  assign bus.o_seed_fix = fix_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: sequence tables plus a randomized run against an
// arithmetic reference model over six configurations sharing one stimulus.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        rst, load, clear, ready;
  logic [63:0] seed;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  localparam int N = 6;
  // 0: fib4 xor, 1: fib4 xor steps2, 2: gal4 xor, 3: fib4 xnor, 4: gal5 xnor, 5: default 25-bit
  int          cfg_w      [N] = '{4, 4, 4, 4, 5, 25};
  logic [63:0] cfg_taps   [N] = '{64'hC, 64'hC, 64'h3, 64'hC, 64'h5, 64'h1200000};
  int          cfg_galois [N] = '{0, 0, 1, 0, 1, 0};
  int          cfg_xnor   [N] = '{0, 0, 0, 1, 1, 0};
  int          cfg_steps  [N] = '{1, 2, 1, 1, 1, 1};

  logic [3:0] fib_seq  [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] fib2_seq [16] = '{4'h1, 4'h4, 4'h3, 4'hD, 4'h5, 4'h7, 4'hE, 4'h8,
                                4'h2, 4'h9, 4'h6, 4'hA, 4'hB, 4'hF, 4'hC, 4'h1};
  logic [3:0] gal_seq  [8]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB};

  lfsr_gen_if #(.WIDTH(4),  .COUNT_W(32)) f4_if ();
  lfsr_gen_if #(.WIDTH(4),  .COUNT_W(32)) f4s2_if ();
  lfsr_gen_if #(.WIDTH(4),  .COUNT_W(32)) g4_if ();
  lfsr_gen_if #(.WIDTH(4),  .COUNT_W(32)) x4_if ();
  lfsr_gen_if #(.WIDTH(5),  .COUNT_W(32)) gx5_if ();
  lfsr_gen_if #(.WIDTH(25), .COUNT_W(32)) d25_if ();

  assign f4_if.i_load   = load;  assign f4_if.i_clear   = clear;
  assign f4_if.i_ready  = ready; assign f4_if.i_seed    = seed[3:0];
  assign f4s2_if.i_load = load;  assign f4s2_if.i_clear = clear;
  assign f4s2_if.i_ready = ready; assign f4s2_if.i_seed = seed[3:0];
  assign g4_if.i_load   = load;  assign g4_if.i_clear   = clear;
  assign g4_if.i_ready  = ready; assign g4_if.i_seed    = seed[3:0];
  assign x4_if.i_load   = load;  assign x4_if.i_clear   = clear;
  assign x4_if.i_ready  = ready; assign x4_if.i_seed    = seed[3:0];
  assign gx5_if.i_load  = load;  assign gx5_if.i_clear  = clear;
  assign gx5_if.i_ready = ready; assign gx5_if.i_seed   = seed[4:0];
  assign d25_if.i_load  = load;  assign d25_if.i_clear  = clear;
  assign d25_if.i_ready = ready; assign d25_if.i_seed   = seed[24:0];

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(0), .FEEDBACK(0), .STEPS(1), .DEFAULT_SEED(4'd1))
    u_f4 (.i_clk(clk), .i_rst(rst), .bus(f4_if));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(0), .FEEDBACK(0), .STEPS(2), .DEFAULT_SEED(4'd1))
    u_f4s2 (.i_clk(clk), .i_rst(rst), .bus(f4s2_if));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .MODE(1), .FEEDBACK(0), .STEPS(1), .DEFAULT_SEED(4'd1))
    u_g4 (.i_clk(clk), .i_rst(rst), .bus(g4_if));
  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .MODE(0), .FEEDBACK(1), .STEPS(1), .DEFAULT_SEED(4'd1))
    u_x4 (.i_clk(clk), .i_rst(rst), .bus(x4_if));
  lfsr_gen #(.WIDTH(5), .TAPS(5'b00101), .MODE(1), .FEEDBACK(1), .STEPS(1), .DEFAULT_SEED(5'd1))
    u_gx5 (.i_clk(clk), .i_rst(rst), .bus(gx5_if));
  lfsr_gen u_d25 (.i_clk(clk), .i_rst(rst), .bus(d25_if));

  logic [63:0] obs_data  [N];
  logic [31:0] obs_count [N];
  logic        obs_valid [N];
  logic        obs_wrap  [N];
  logic        obs_fix   [N];

  assign obs_data[0] = {60'd0, f4_if.o_data};   assign obs_count[0] = f4_if.o_count;
  assign obs_data[1] = {60'd0, f4s2_if.o_data}; assign obs_count[1] = f4s2_if.o_count;
  assign obs_data[2] = {60'd0, g4_if.o_data};   assign obs_count[2] = g4_if.o_count;
  assign obs_data[3] = {60'd0, x4_if.o_data};   assign obs_count[3] = x4_if.o_count;
  assign obs_data[4] = {59'd0, gx5_if.o_data};  assign obs_count[4] = gx5_if.o_count;
  assign obs_data[5] = {39'd0, d25_if.o_data};  assign obs_count[5] = d25_if.o_count;
  assign obs_valid = '{f4_if.o_valid, f4s2_if.o_valid, g4_if.o_valid,
                       x4_if.o_valid, gx5_if.o_valid, d25_if.o_valid};
  assign obs_wrap  = '{f4_if.o_wrap, f4s2_if.o_wrap, g4_if.o_wrap,
                       x4_if.o_wrap, gx5_if.o_wrap, d25_if.o_wrap};
  assign obs_fix   = '{f4_if.o_seed_fix, f4s2_if.o_seed_fix, g4_if.o_seed_fix,
                       x4_if.o_seed_fix, gx5_if.o_seed_fix, d25_if.o_seed_fix};

  // Reference model state
  logic        m_valid [N];
  logic [63:0] m_data  [N];
  logic [63:0] m_seed  [N];
  logic [31:0] m_count [N];
  logic        m_wrap  [N];
  logic        m_fix   [N];

  function automatic logic [63:0] ref_next(input int id, input logic [63:0] s_in);
    logic [63:0] mask, s, t;
    int          par;
    mask = (64'd1 << cfg_w[id]) - 64'd1;
    s = s_in;
    for (int k = 0; k < cfg_steps[id]; k++) begin
      if (cfg_galois[id] == 0) begin
        par = $countones(s & cfg_taps[id]) % 2;
        if (cfg_xnor[id] == 1) par = 1 - par;
        s = ((s << 1) | 64'(par)) & mask;
      end else begin
        // XNOR Galois modelled as XOR Galois on the complemented state
        t = (cfg_xnor[id] == 1) ? (~s & mask) : s;
        if (t[cfg_w[id]-1]) t = ((t << 1) & mask) ^ cfg_taps[id];
        else                t = (t << 1) & mask;
        s = (cfg_xnor[id] == 1) ? (~t & mask) : t;
      end
    end
    return s;
  endfunction

  task automatic model_apply();
    logic [63:0] mask, lock, sd, nx;
    for (int id = 0; id < N; id++) begin
      mask = (64'd1 << cfg_w[id]) - 64'd1;
      lock = (cfg_xnor[id] == 1) ? mask : 64'd0;
      sd   = seed & mask;
      m_wrap[id] = 1'b0;
      m_fix[id]  = 1'b0;
      if (rst) begin
        m_valid[id] = 1'b0; m_data[id] = 64'd1; m_seed[id] = 64'd1; m_count[id] = 32'd0;
      end else if (load) begin
        m_fix[id]   = (sd == lock);
        if (sd == lock) sd = 64'd1;
        m_valid[id] = 1'b1; m_data[id] = sd; m_seed[id] = sd; m_count[id] = 32'd0;
      end else if (clear) begin
        m_valid[id] = 1'b0;
      end else if (m_valid[id] && ready) begin
        nx = ref_next(id, m_data[id]);
        m_data[id]  = nx;
        m_count[id] = m_count[id] + 32'd1;
        m_wrap[id]  = (nx == m_seed[id]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; clear = 1'b0; ready = 1'b0; seed = 64'd0;
    tick(); tick();
    for (int id = 0; id < N; id++) begin
      if ({obs_valid[id], obs_data[id], obs_count[id], obs_wrap[id], obs_fix[id]}
          !== {1'b0, 64'd1, 32'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%b d=%h c=%0d w=%b f=%b expected v=0 d=1 c=0 w=0 f=0",
                 id, obs_valid[id], obs_data[id], obs_count[id], obs_wrap[id], obs_fix[id]);
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  task automatic test_sequences();
    seed = 64'd1; load = 1'b1; ready = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ({f4_if.o_valid, f4_if.o_data, f4_if.o_count, f4_if.o_wrap}
          !== {1'b1, fib_seq[i], 32'(i), (i == 15)}) begin
        errors++;
        $display("FAIL fib_seq[%0d]: got v=%b d=%h c=%0d w=%b expected v=1 d=%h c=%0d w=%b",
                 i, f4_if.o_valid, f4_if.o_data, f4_if.o_count, f4_if.o_wrap,
                 fib_seq[i], i, (i == 15));
      end
      checks++;
      if ({f4s2_if.o_data, f4s2_if.o_wrap} !== {fib2_seq[i], (i == 15)}) begin
        errors++;
        $display("FAIL fib_steps2[%0d]: got d=%h w=%b expected d=%h w=%b",
                 i, f4s2_if.o_data, f4s2_if.o_wrap, fib2_seq[i], (i == 15));
      end
      checks++;
      if (i < 8) begin
        if (g4_if.o_data !== gal_seq[i]) begin
          errors++;
          $display("FAIL galois_seq[%0d]: got %h expected %h", i, g4_if.o_data, gal_seq[i]);
        end
        checks++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    ready = 1'b0; seed = 64'd1; load = 1'b1;
    tick();
    load = 1'b0; ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({g4_if.o_valid, g4_if.o_data, g4_if.o_count} !== {1'b1, 4'h8, 32'd3}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b d=%h c=%0d expected v=1 d=8 c=3",
                 i, g4_if.o_valid, g4_if.o_data, g4_if.o_count);
      end
      checks++;
    end
    ready = 1'b1;
    tick();
    if ({g4_if.o_data, g4_if.o_count} !== {4'h3, 32'd4}) begin
      errors++;
      $display("FAIL stall_resume: got d=%h c=%0d expected d=3 c=4", g4_if.o_data, g4_if.o_count);
    end
    checks++;
    ready = 1'b0;
  endtask

  task automatic test_seed_fix();
    ready = 1'b0; seed = 64'd0; load = 1'b1;
    tick();
    load = 1'b0;
    if ({f4_if.o_data, f4_if.o_seed_fix, x4_if.o_data, x4_if.o_seed_fix}
        !== {4'h1, 1'b1, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL seed_fix_xor: got xor d=%h f=%b xnor d=%h f=%b expected 1,1,0,0",
               f4_if.o_data, f4_if.o_seed_fix, x4_if.o_data, x4_if.o_seed_fix);
    end
    checks++;
    tick();
    if (f4_if.o_seed_fix !== 1'b0) begin
      errors++;
      $display("FAIL seed_fix_pulse: got %b expected 0", f4_if.o_seed_fix);
    end
    checks++;
    seed = 64'hF; load = 1'b1;
    tick();
    load = 1'b0;
    if ({x4_if.o_data, x4_if.o_seed_fix, f4_if.o_data, f4_if.o_seed_fix}
        !== {4'h1, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL seed_fix_xnor: got xnor d=%h f=%b xor d=%h f=%b expected 1,1,f,0",
               x4_if.o_data, x4_if.o_seed_fix, f4_if.o_data, f4_if.o_seed_fix);
    end
    checks++;
    tick();
    if (x4_if.o_seed_fix !== 1'b0) begin
      errors++;
      $display("FAIL seed_fix_xnor_pulse: got %b expected 0", x4_if.o_seed_fix);
    end
    checks++;
  endtask

  task automatic test_load_clear();
    ready = 1'b0; seed = 64'd1; load = 1'b1;
    tick();
    load = 1'b0; ready = 1'b1;
    tick(); tick();
    if ({f4_if.o_data, f4_if.o_count} !== {4'h4, 32'd2}) begin
      errors++;
      $display("FAIL pre_reload: got d=%h c=%0d expected d=4 c=2", f4_if.o_data, f4_if.o_count);
    end
    checks++;
    seed = 64'd5; load = 1'b1;
    tick();
    load = 1'b0; ready = 1'b0;
    if ({f4_if.o_valid, f4_if.o_data, f4_if.o_count} !== {1'b1, 4'h5, 32'd0}) begin
      errors++;
      $display("FAIL load_beats_xfer: got v=%b d=%h c=%0d expected v=1 d=5 c=0",
               f4_if.o_valid, f4_if.o_data, f4_if.o_count);
    end
    checks++;
    clear = 1'b1;
    tick();
    clear = 1'b0; ready = 1'b1;
    if ({f4_if.o_valid, f4_if.o_data} !== {1'b0, 4'h5}) begin
      errors++;
      $display("FAIL clear: got v=%b d=%h expected v=0 d=5", f4_if.o_valid, f4_if.o_data);
    end
    checks++;
    tick();
    if ({f4_if.o_valid, f4_if.o_data, f4_if.o_count} !== {1'b0, 4'h5, 32'd0}) begin
      errors++;
      $display("FAIL idle_hold: got v=%b d=%h c=%0d expected v=0 d=5 c=0",
               f4_if.o_valid, f4_if.o_data, f4_if.o_count);
    end
    checks++;
    seed = 64'd9; load = 1'b1; clear = 1'b1;
    tick();
    load = 1'b0; clear = 1'b0; ready = 1'b0;
    if ({f4_if.o_valid, f4_if.o_data} !== {1'b1, 4'h9}) begin
      errors++;
      $display("FAIL load_beats_clear: got v=%b d=%h expected v=1 d=9", f4_if.o_valid, f4_if.o_data);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    seed = 64'h1234; load = 1'b1; ready = 1'b1;
    tick();
    load = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; ready = 1'b0;
    for (int id = 0; id < N; id++) begin
      if ({obs_valid[id], obs_data[id], obs_count[id]} !== {1'b0, 64'd1, 32'd0}) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got v=%b d=%h c=%0d expected v=0 d=1 c=0",
                 id, obs_valid[id], obs_data[id], obs_count[id]);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    int r;
    rst = 1'b1; load = 1'b0; clear = 1'b0; ready = 1'b0; seed = 64'd0;
    model_apply();
    tick();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst   = ($urandom_range(0, 299) == 0);
      ready = ($urandom_range(0, 3) != 0);
      load  = (cyc == 0) || ($urandom_range(0, 39) == 0);
      clear = ($urandom_range(0, 59) == 0);
      r     = $urandom_range(0, 3);
      seed  = (r == 0) ? 64'd0 : (r == 1) ? {64{1'b1}} : {$urandom, $urandom};
      model_apply();
      tick();
      for (int id = 0; id < N; id++) begin
        if ({obs_valid[id], obs_data[id], obs_count[id], obs_wrap[id], obs_fix[id]}
            !== {m_valid[id], m_data[id], m_count[id], m_wrap[id], m_fix[id]}) begin
          errors++;
          $display("FAIL random[%0d] cyc %0d: got v=%b d=%h c=%0d w=%b f=%b expected v=%b d=%h c=%0d w=%b f=%b",
                   id, cyc, obs_valid[id], obs_data[id], obs_count[id], obs_wrap[id], obs_fix[id],
                   m_valid[id], m_data[id], m_count[id], m_wrap[id], m_fix[id]);
        end
        checks++;
      end
    end
    rst = 1'b0; load = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequences();
    test_stall();
    test_seed_fix();
    test_load_clear();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
